ram_dp_init: RTL and testbench
==============================

Name: ram_dp_init

Overview:
- Simple dual-port synchronous RAM (one write port, one read port) with per-byte write enables, a read-valid strobe, and a configurable read-during-write policy.
- Built-in clear engine: after every reset it sweeps the array and writes zero to every word.
- Generalised replacement for the team's single-port register-array RAM. Used as the storage element behind FIFOs, lookup tables and scratchpads.

Parameters:
- WIDTH, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 16, number of words; need not be a power of two.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- BE_WIDTH, WIDTH/8, number of byte-enable lanes.
- RDW_MODE, 0, same-address read during write: 0 = old data, 1 = new data (write-through, merged per byte lane).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  WIDTH  write data.
- wr_be  in  BE_WIDTH  byte enables; bit i covers wr_data[8i+7:8i].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  WIDTH  read data.
- rd_valid  out  1  rd_data carries a fresh read result this cycle.
- init_busy  out  1  clear sweep in progress; requests are ignored.
- init_done  out  1  array cleared and ready; stays high until the next rst.

Behaviour:
- Interface: clock clk; reset rst is synchronous and active-high.
- Reset values while rst=1: rd_data=0, rd_valid=0, init_busy=1, init_done=0, sweep counter=0, FSM state=INIT.
- FSM states: INIT and READY.
  - INIT: each cycle writes 0 to mem[cnt], then cnt+1. Memory is not accessed while rst=1.
  - INIT exits after cnt=DEPTH-1 is written. The sweep takes exactly DEPTH cycles after rst deasserts.
  - On the first cycle after the sweep: state=READY, init_busy=0, init_done=1.
  - READY is held until rst.
- In INIT, wr_en and rd_en are ignored: no write, rd_valid stays 0.
- rst asserted at any time (mid-sweep or mid-operation) returns the FSM to INIT with cnt=0. The full sweep restarts and the whole array is re-cleared.
- Write (READY, wr_en=1): for each lane with wr_be[i]=1, mem[wr_addr] byte i <= wr_data byte i. Other lanes keep their value. wr_be=0 writes nothing.
- Read (READY, rd_en=1): latency 1.
  - rd_data <= mem[rd_addr] and rd_valid <= 1 on the next edge.
  - With rd_en=0: rd_valid <= 0 and rd_data holds its previous value.
- Same-address collision (wr_en & rd_en, wr_addr==rd_addr):
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the post-write word, with enabled lanes taken from wr_data and the others from memory.
  - The write always completes.
- Different addresses: reads and writes proceed fully independently in the same cycle.
- Address >= DEPTH (only possible when DEPTH is not a power of two): the write is dropped; the read returns 0 with rd_valid=1.
- Reads of never-written locations after init return 0.

Optional Feature:
- Macro: RAM_OUTREG_EN.
- Defined: an extra output register stage is added.
  - Read latency is 2: rd_data and rd_valid are both delayed one cycle.
  - The stage-2 register resets to 0 and loads only when the stage-1 valid is set; otherwise it holds.
  - RDW collision semantics are decided at stage 1 and are unchanged.
- Undefined: latency 1 as above; no extra flops.

Test Plan (WIDTH=32, DEPTH=16 unless noted):
- Init: deassert rst, then poll → init_busy=1 for exactly 16 cycles, then init_busy=0 and init_done=1. Reading addresses 0..15 then returns 0x00000000 with rd_valid 1 cycle after each rd_en.
- Byte enables: write 0xAABBCCDD to addr 3 with be=4'b1111, then 0x11223344 with be=4'b0101, then read addr 3 → 0xAA22CC44.
- Collision: addr 5 holds 0x12345678; wr_en+rd_en to addr 5 with data 0xCAFEF00D, be=4'b1111 → RDW_MODE=0 returns 0x12345678 and RDW_MODE=1 returns 0xCAFEF00D. A following read returns 0xCAFEF00D in both modes.
- Ignored during init: wr_en=1 to addr 2 with data 0xFFFFFFFF and rd_en=1 during the sweep → rd_valid stays 0. After init, a read of addr 2 returns 0.
- Reset mid-operation: write 0xDEADBEEF to addr 7, assert rst for 1 cycle at sweep count 8 of a second init → sweep restarts with 16 busy cycles, and addr 7 then reads 0.
- DEPTH=12, out of range, with and without RAM_OUTREG_EN: write addr 13 then read addr 13 → rd_data=0, rd_valid=1 at latency 1 (macro undefined) or latency 2 (macro defined). Back-to-back reads of 0..11 stream one result per cycle.

Source files
------------

// File: rtl/ram_dp_init.sv
// rtl/ram_dp_init.sv - dual-port RAM with byte enables, RDW policy and post-reset clear sweep; RAM_OUTREG_EN adds an output register stage
module ram_dp_init #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int BE_WIDTH   = WIDTH / 8,
  parameter int RDW_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [BE_WIDTH-1:0]   wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  init_busy,
  output logic                  init_done
);

  // One extra bit so DEPTH itself is representable when DEPTH is a power of two
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0]        mem [DEPTH];
  logic                    wr_ok;
  logic                    rd_ok;
  logic                    rd_in_range;
  logic                    collide;
  logic [WIDTH-1:0]        rd_word;
  logic [WIDTH-1:0]        rd_data_s1;
  logic                    rd_valid_s1;

  assign init_busy   = (state == INIT);
  assign init_done   = (state == READY);
  assign wr_ok       = init_done & wr_en & ({1'b0, wr_addr} < DEPTH_W);
  assign rd_ok       = init_done & rd_en;
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
  assign collide     = wr_ok & rd_en & (wr_addr == rd_addr);

  // FSM state and sweep counter; reset always restarts the clear sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: step through every word once, then park in READY
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == INIT) begin
      if (cnt == LAST) begin
        state_nxt = READY;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + ADDR_WIDTH'(1);
      end
    end
  end

  // Array write: zero fill during the sweep, byte-masked user writes once ready
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[cnt] <= '0;
      end else if (wr_ok) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
          if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Read word with the collision policy applied; out-of-range reads give zero
  always_comb begin
    rd_word = '0;
    if (rd_in_range) rd_word = mem[rd_addr];
    if (RDW_MODE == 1 && collide) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  // First read stage: data loads only on a read, valid is a one-cycle strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_s1  <= '0;
      rd_valid_s1 <= 1'b0;
    end else begin
      rd_valid_s1 <= rd_ok;
      if (rd_ok) rd_data_s1 <= rd_word;
    end
  end

`ifdef RAM_OUTREG_EN
  logic [WIDTH-1:0] rd_data_s2;
  logic             rd_valid_s2;

  // Output stage: follows stage 1 one cycle later, data holds between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_s2  <= '0;
      rd_valid_s2 <= 1'b0;
    end else begin
      rd_valid_s2 <= rd_valid_s1;
      if (rd_valid_s1) rd_data_s2 <= rd_data_s1;
    end
  end

  assign rd_data  = rd_data_s2;
  assign rd_valid = rd_valid_s2;
`else
  assign rd_data  = rd_data_s1;
  assign rd_valid = rd_valid_s1;
`endif

endmodule

// File: tb/tb_ram_dp_init.sv
// tb/tb_ram_dp_init.sv - directed self-checking bench for ram_dp_init (RDW old/new data, DEPTH=12 out of range)
module tb_ram_dp_init;

`ifdef RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [3:0]  rd_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;

  logic [31:0] d0, d1, d12;
  logic        v0, v1, v12;
  logic        b0, b1, b12;
  logic        dn0, dn1, dn12;

  int n_checks = 0;
  int n_pass   = 0;
  int n_busy, n_busy12;
  logic any_v;

  always #5 clk = ~clk;

  ram_dp_init #(.WIDTH(32), .DEPTH(16), .RDW_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d0), .rd_valid(v0), .init_busy(b0), .init_done(dn0)
  );

  ram_dp_init #(.WIDTH(32), .DEPTH(16), .RDW_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d1), .rd_valid(v1), .init_busy(b1), .init_done(dn1)
  );

  ram_dp_init #(.WIDTH(32), .DEPTH(12), .RDW_MODE(0)) dut12 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d12), .rd_valid(v12), .init_busy(b12), .init_done(dn12)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    rd_en = 1'b1; rd_addr = a;
    step();
    rd_en = 1'b0;
    repeat (LAT - 1) step();
  endtask

  task automatic wr_rd(input logic [3:0] wa, input logic [31:0] d, input logic [3:0] be,
                       input logic [3:0] ra);
    wr_en = 1'b1; wr_addr = wa; wr_data = d; wr_be = be;
    rd_en = 1'b1; rd_addr = ra;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (LAT - 1) step();
  endtask

  // Counts edges until dut0 leaves INIT; requests are dropped after 10 edges
  task automatic wait_ready(output int n, output int n12, output logic anyv);
    n = 0; n12 = 0; anyv = 1'b0;
    while (n < 200) begin
      step();
      n++;
      if (n == 10) begin wr_en = 1'b0; rd_en = 1'b0; end
      anyv = anyv | v0 | v1 | v12;
      if (!b12 && n12 == 0) n12 = n;
      if (!b0) break;
    end
    if (n >= 200) $display("FAIL ready_timeout: got %0d edges expected 16", n);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) step();
    check("rst_busy", 32'(b0), 32'd1);
    check("rst_done", 32'(dn0), 32'd0);
    check("rst_valid", 32'(v0), 32'd0);
    check("rst_data", d0, 32'h0);
    check("rst_busy12", 32'(b12), 32'd1);

    // Release reset with requests active; they must be ignored during the sweep
    rst = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd2;
    wait_ready(n_busy, n_busy12, any_v);
    check("init_cycles", 32'(n_busy), 32'd16);
    check("init_cycles12", 32'(n_busy12), 32'd12);
    check("init_no_valid", 32'(any_v), 32'd0);
    check("init_done", 32'(dn0), 32'd1);
    check("init_busy_low", 32'(b0), 32'd0);
    check("init_done12", 32'(dn12), 32'd1);

    // Whole array cleared, including the address written during the sweep
    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      check($sformatf("clr_data%0d", a), d0, 32'h0);
      check($sformatf("clr_valid%0d", a), 32'(v0), 32'd1);
    end
    step();
    check("valid_drop", 32'(v0), 32'd0);

    // Byte enables
    wr(4'd3, 32'hAABB_CCDD, 4'b1111);
    wr(4'd3, 32'h1122_3344, 4'b0101);
    rd(4'd3);
    check("be_m0", d0, 32'hAA22_CC44);
    check("be_m1", d1, 32'hAA22_CC44);

    // Same-address collision, full and partial lanes
    wr(4'd5, 32'h1234_5678, 4'b1111);
    wr_rd(4'd5, 32'hCAFE_F00D, 4'b1111, 4'd5);
    check("col_m0", d0, 32'h1234_5678);
    check("col_m1", d1, 32'hCAFE_F00D);
    check("col_valid", 32'(v1), 32'd1);
    rd(4'd5);
    check("col_after_m0", d0, 32'hCAFE_F00D);
    check("col_after_m1", d1, 32'hCAFE_F00D);
    wr_rd(4'd5, 32'h1122_3344, 4'b0011, 4'd5);
    check("colp_m0", d0, 32'hCAFE_F00D);
    check("colp_m1", d1, 32'hCAFE_3344);
    rd(4'd5);
    check("colp_after_m0", d0, 32'hCAFE_3344);
    check("colp_after_m1", d1, 32'hCAFE_3344);

    // Independent addresses in the same cycle
    wr_rd(4'd9, 32'h0BAD_CAFE, 4'b1111, 4'd3);
    check("diff_m0", d0, 32'hAA22_CC44);
    check("diff_m1", d1, 32'hAA22_CC44);
    rd(4'd9);
    check("diff_wr", d0, 32'h0BAD_CAFE);

    // Empty byte mask writes nothing; data holds when no read is issued
    wr(4'd9, 32'hFFFF_FFFF, 4'b0000);
    rd(4'd9);
    check("be_zero", d0, 32'h0BAD_CAFE);
    step();
    check("hold_valid", 32'(v0), 32'd0);
    check("hold_data", d0, 32'h0BAD_CAFE);

    // DEPTH=12: out-of-range write dropped, read returns zero with valid
    wr(4'd13, 32'h5555_5555, 4'b1111);
    rd(4'd13);
    check("oor13_data", d12, 32'h0);
    check("oor13_valid", 32'(v12), 32'd1);
    check("inr13_depth16", d0, 32'h5555_5555);
    rd(4'd12);
    check("oor12_data", d12, 32'h0);

    // Back-to-back streaming reads of the full DEPTH=12 array
    for (int k = 0; k < 12; k++) wr(4'(k), 32'hA000_0000 | 32'(k), 4'b1111);
    for (int c = 0; c < 12 + LAT - 1; c++) begin
      rd_en = (c < 12);
      rd_addr = 4'(c);
      step();
      if (c >= LAT - 1) begin
        check($sformatf("stream_valid%0d", c - LAT + 1), 32'(v12), 32'd1);
        check($sformatf("stream_data%0d", c - LAT + 1), d12, 32'hA000_0000 | 32'(c - LAT + 1));
      end
    end
    rd_en = 1'b0;
    repeat (LAT) step();
    check("stream_end", 32'(v12), 32'd0);

    // Reset in the middle of a second sweep restarts the full clear
    wr(4'd7, 32'hDEAD_BEEF, 4'b1111);
    rd(4'd7);
    check("pre_rst7", d0, 32'hDEAD_BEEF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (8) step();
    check("mid_sweep_busy", 32'(b0), 32'd1);
    rst = 1'b1;
    step();
    check("rerst_busy", 32'(b0), 32'd1);
    check("rerst_done", 32'(dn0), 32'd0);
    check("rerst_valid", 32'(v0), 32'd0);
    check("rerst_data", d0, 32'h0);
    rst = 1'b0;
    wait_ready(n_busy, n_busy12, any_v);
    check("reinit_cycles", 32'(n_busy), 32'd16);
    check("reinit_cycles12", 32'(n_busy12), 32'd12);
    rd(4'd7);
    check("reinit_rd7", d0, 32'h0);
    rd(4'd3);
    check("reinit_rd3_m0", d0, 32'h0);
    check("reinit_rd3_m1", d1, 32'h0);
    rd(4'd5);
    check("reinit_rd5_12", d12, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
